// File: rtl/video_pkg.sv
// Shared timing presets, sync bundle and helpers
// for the parametrised video timing generator.
package video_pkg;

  typedef struct packed {
    int h_active;
    int h_fp;
    int h_sync;
    int h_bp;
    int v_active;
    int v_fp;
    int v_sync;
    int v_bp;
  } timing_t;

  localparam timing_t TIMING_720P60 =
    '{1280, 110, 40, 220, 720, 5, 5, 20};

  localparam timing_t TIMING_480P60 =
    '{640, 16, 96, 48, 480, 10, 2, 33};

  typedef struct packed {
    logic de;
    logic hsync;
    logic vsync;
    logic line_start;
    logic frame_start;
  } sync_t;

  function automatic int span_total(
    int active, int fp, int sync, int bp
  );
    return active + fp + sync + bp;
  endfunction

  function automatic logic sync_idle(bit pol);
    return ~pol;
  endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// Raster output bundle of the video timing generator
// plus its run enable.
interface video_timing_gen_if #(
  parameter int COORD_W = 16
);

  logic               en;
  logic               pix_ce;
  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;
  logic               de;
  logic               hsync;
  logic               vsync;
  logic               line_start;
  logic               frame_start;
  logic [7:0]         frame_count;

  modport master (
    input  en,
    output pix_ce, x, y, de,
    output hsync, vsync,
    output line_start, frame_start,
    output frame_count
  );

  modport slave (
    output en,
    input  pix_ce, x, y, de,
    input  hsync, vsync,
    input  line_start, frame_start,
    input  frame_count
  );

endinterface

// File: rtl/video_delay_line.sv
// Fixed-depth shift register with synchronous
// active-low reset to a chosen idle value.
module video_delay_line #(
  parameter int               DEPTH   = 1,
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_wire
    logic unused;
    assign unused = clk ^ reset_n;
    assign q = d;
  end else begin : g_pipe
    logic [WIDTH-1:0] pipe [DEPTH];

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        for (int i = 0; i < DEPTH; i++)
          pipe[i] <= RST_VAL;
      end else begin
        pipe[0] <= d;
        for (int i = 1; i < DEPTH; i++)
          pipe[i] <= pipe[i-1];
      end
    end

    assign q = pipe[DEPTH-1];
  end

endmodule

// File: rtl/video_timing_gen.sv
// VESA-style raster timing from one fast clock with
// an internal pixel enable and aligned sync outputs.
module video_timing_gen
  import video_pkg::*;
#(
  parameter int H_ACTIVE   = TIMING_720P60.h_active,
  parameter int H_FP       = TIMING_720P60.h_fp,
  parameter int H_SYNC     = TIMING_720P60.h_sync,
  parameter int H_BP       = TIMING_720P60.h_bp,
  parameter int V_ACTIVE   = TIMING_720P60.v_active,
  parameter int V_FP       = TIMING_720P60.v_fp,
  parameter int V_SYNC     = TIMING_720P60.v_sync,
  parameter int V_BP       = TIMING_720P60.v_bp,
  parameter bit HS_POL     = 1'b1,
  parameter bit VS_POL     = 1'b1,
  parameter int CLK_DIV    = 2,
  parameter int PIPE_DELAY = 0,
  parameter int COORD_W    = 16
) (
  input logic                clk,
  input logic                reset_n,
  video_timing_gen_if.master vif
);

  localparam int H_TOTAL =
    span_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL =
    span_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [2:0] DIV_LAST = 3'(CLK_DIV - 1);

  localparam logic [COORD_W-1:0] ONE = 1;
  localparam logic [COORD_W-1:0] H_LAST =
    COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST =
    COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] HA =
    COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] VA =
    COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] HS_ON =
    COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] HS_OFF =
    COORD_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [COORD_W-1:0] VS_ON =
    COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] VS_OFF =
    COORD_W'(V_ACTIVE + V_FP + V_SYNC);

  localparam sync_t IDLE = '{
    de:          1'b0,
    hsync:       sync_idle(HS_POL),
    vsync:       sync_idle(VS_POL),
    line_start:  1'b0,
    frame_start: 1'b0
  };

  logic [2:0]         div;
  logic               pix_ce;
  logic [COORD_W-1:0] h;
  logic [COORD_W-1:0] v;
  logic [7:0]         fcnt;
  logic               h_end;
  logic               v_end;
  sync_t              s0_next;
  sync_t              s0;
  sync_t              sd;

  assign h_end = (h == H_LAST);
  assign v_end = (v == V_LAST);

  // divider free-runs so pix_ce phase survives en
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div    <= '0;
      pix_ce <= 1'b0;
    end else begin
      pix_ce <= (div == DIV_LAST);
      div    <= (div == DIV_LAST) ? '0 : div + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      h    <= '0;
      v    <= '0;
      fcnt <= '0;
    end else begin
      if (pix_ce && h_end && v_end)
        fcnt <= fcnt + 8'd1;
      if (!vif.en) begin
        h <= '0;
        v <= '0;
      end else if (pix_ce) begin
        h <= h_end ? '0 : h + ONE;
        if (h_end)
          v <= v_end ? '0 : v + ONE;
      end
    end
  end

  always_comb begin
    s0_next = IDLE;
    if (vif.en) begin
      s0_next.de = (h < HA) && (v < VA);
      if (h >= HS_ON && h < HS_OFF)
        s0_next.hsync = HS_POL;
      if (v >= VS_ON && v < VS_OFF)
        s0_next.vsync = VS_POL;
      s0_next.line_start = pix_ce && (h == '0);
      s0_next.frame_start =
        pix_ce && (h == '0) && (v == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n)
      s0 <= IDLE;
    else
      s0 <= s0_next;
  end

  video_delay_line #(
    .DEPTH   (PIPE_DELAY),
    .WIDTH   ($bits(sync_t)),
    .RST_VAL (IDLE)
  ) u_dly (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (s0),
    .q       (sd)
  );

  assign vif.pix_ce      = pix_ce;
  assign vif.x           = h;
  assign vif.y           = v;
  assign vif.frame_count = fcnt;
  assign vif.de          = sd.de;
  assign vif.hsync       = sd.hsync;
  assign vif.vsync       = sd.vsync;
  assign vif.line_start  = sd.line_start;
  assign vif.frame_start = sd.frame_start;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench: three generator configurations against a
// raster-position reference model plus fixed checks.
module tb_video_timing_gen;

  localparam int HT = 14;
  localparam int VT = 8;
  localparam int FR = HT * VT;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic en = 1'b1;

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit armed = 1'b0;

  video_timing_gen_if #(.COORD_W(16)) v0 ();
  video_timing_gen_if #(.COORD_W(16)) v1 ();
  video_timing_gen_if #(.COORD_W(16)) v2 ();

  assign v0.en = en;
  assign v1.en = en;
  assign v2.en = en;

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1),
    .CLK_DIV(1), .PIPE_DELAY(0), .COORD_W(16)
  ) dut0 (.clk(clk), .reset_n(reset_n), .vif(v0.master));

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1),
    .CLK_DIV(3), .PIPE_DELAY(0), .COORD_W(16)
  ) dut1 (.clk(clk), .reset_n(reset_n), .vif(v1.master));

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b1),
    .CLK_DIV(1), .PIPE_DELAY(2), .COORD_W(16)
  ) dut2 (.clk(clk), .reset_n(reset_n), .vif(v2.master));

  function automatic int dv(int k);
    return (k == 1) ? 3 : 1;
  endfunction

  function automatic int pd(int k);
    return (k == 2) ? 2 : 0;
  endfunction

  function automatic bit hp(int k);
    return (k != 2);
  endfunction

  function automatic logic [4:0] idle5(int k);
    return {1'b0, !hp(k), 1'b0, 1'b0, 1'b0};
  endfunction

  // expected {de,hs,vs,ls,fs} for raster position p
  function automatic logic [4:0] decode(
    int k, int p, bit e, bit pce
  );
    int x, y;
    bit de, hs, vs, ls, fs;
    if (!e) return idle5(k);
    x  = p % HT;
    y  = p / HT;
    de = (x < 8) && (y < 4);
    hs = (x >= 10 && x < 13) ? hp(k) : !hp(k);
    vs = (y >= 5) && (y < 7);
    ls = pce && (x == 0);
    fs = ls && (y == 0);
    return {de, hs, vs, ls, fs};
  endfunction

  int         m_n  [3];
  int         m_p  [3];
  int         m_fc [3];
  bit         m_pce[3];
  logic [4:0] m_s0 [3];
  logic [4:0] m_dl [3][16];

  initial forever begin
    @(posedge clk);
    if (!reset_n) armed = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (!reset_n) begin
        m_n[k]   = 0;
        m_p[k]   = 0;
        m_fc[k]  = 0;
        m_pce[k] = 1'b0;
        m_s0[k]  = idle5(k);
        for (int i = 0; i < 16; i++)
          m_dl[k][i] = idle5(k);
      end else begin
        for (int i = 15; i > 0; i--)
          m_dl[k][i] = m_dl[k][i-1];
        m_dl[k][0] = m_s0[k];
        m_s0[k] = decode(k, m_p[k], en, m_pce[k]);
        if (m_pce[k] && m_p[k] == FR - 1)
          m_fc[k] = (m_fc[k] + 1) % 256;
        if (!en)
          m_p[k] = 0;
        else if (m_pce[k])
          m_p[k] = (m_p[k] + 1) % FR;
        m_n[k]   = m_n[k] + 1;
        m_pce[k] = (m_n[k] % dv(k)) == 0;
      end
    end
  end

  function automatic logic [45:0] expv(int k);
    logic [4:0] s;
    s = (pd(k) == 0) ? m_s0[k] : m_dl[k][pd(k)-1];
    return {m_pce[k], 16'(m_p[k] % HT),
            16'(m_p[k] / HT), 8'(m_fc[k]), s};
  endfunction

  logic [45:0] act [3];

  assign act[0] = {v0.pix_ce, v0.x, v0.y,
    v0.frame_count, v0.de, v0.hsync, v0.vsync,
    v0.line_start, v0.frame_start};
  assign act[1] = {v1.pix_ce, v1.x, v1.y,
    v1.frame_count, v1.de, v1.hsync, v1.vsync,
    v1.line_start, v1.frame_start};
  assign act[2] = {v2.pix_ce, v2.x, v2.y,
    v2.frame_count, v2.de, v2.hsync, v2.vsync,
    v2.line_start, v2.frame_start};

  initial forever begin
    @(negedge clk);
    if (armed) begin
      for (int k = 0; k < 3; k++) begin
        logic [45:0] e;
        e = expv(k);
        n_cmp++;
        if (act[k] !== e) begin
          n_bad++;
          $display("FAIL model_dut%0d t=%0t got %h want %h",
                   k, $time, act[k], e);
        end
      end
    end
  end

  task automatic check(string name, int got, int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d",
               name, got, want);
    end
  endtask

  task automatic measure0(
    output int nde, output int nhs, output int nvs,
    output int nls, output int nfs, output int fhs
  );
    nde = 0; nhs = 0; nvs = 0;
    nls = 0; nfs = 0; fhs = -1;
    for (int i = 0; i < FR; i++) begin
      if (i > 0) @(negedge clk);
      nde += int'(v0.de);
      nhs += int'(v0.hsync);
      nvs += int'(v0.vsync);
      nls += int'(v0.line_start);
      nfs += int'(v0.frame_start);
      if (v0.hsync && fhs < 0) fhs = i;
    end
  endtask

  task automatic check_frame0(string tag);
    int nde, nhs, nvs, nls, nfs, fhs;
    measure0(nde, nhs, nvs, nls, nfs, fhs);
    check({tag, "_de_clks"}, nde, 32);
    check({tag, "_hs_clks"}, nhs, 24);
    check({tag, "_vs_clks"}, nvs, 28);
    check({tag, "_line_starts"}, nls, 8);
    check({tag, "_frame_starts"}, nfs, 1);
    check({tag, "_hs_after_de"}, fhs, 10);
  endtask

  initial begin
    int cnt, fcs, prev, nde, npce, nls, run, badrun;
    int nlow;
    bit wrapped;
    logic [15:0] px;

    reset_n = 1'b0;
    en = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_x", v0.x, 0);
    check("rst_y", v0.y, 0);
    check("rst_de", v0.de, 0);
    check("rst_hsync", v0.hsync, 0);
    check("rst_vsync", v0.vsync, 0);
    check("rst_fc", v0.frame_count, 0);
    check("rst_hsync_pol0", v2.hsync, 1);

    reset_n = 1'b1;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!v0.frame_start && cnt < 50);
    check("first_fs_lag", cnt, 2);

    check_frame0("frame0");
    check("fc_after_1", v0.frame_count, 1);
    @(negedge clk);
    check_frame0("frame1");
    check("fc_after_2", v0.frame_count, 2);

    cnt = 0;
    while (!v1.frame_start && cnt < 400) begin
      @(negedge clk);
      cnt++;
    end
    check("div3_fs_seen", int'(v1.frame_start), 1);
    nde = 0; npce = 0; nls = 0;
    run = -1; badrun = 0; px = v1.x;
    for (int i = 0; i < 3 * FR; i++) begin
      if (i > 0) @(negedge clk);
      nde  += int'(v1.de);
      npce += int'(v1.pix_ce);
      nls  += int'(v1.line_start);
      if (v1.x != px) begin
        if (run >= 0 && run != 3) badrun++;
        run = 1;
      end else if (run >= 0) begin
        run++;
      end
      px = v1.x;
    end
    check("div3_de_clks", nde, 96);
    check("div3_pix_ce", npce, 112);
    check("div3_line_starts", nls, 8);
    check("div3_x_hold_bad", badrun, 0);

    cnt = 0;
    while (!(v2.x == 0 && v2.y == 0 && v2.pix_ce)
           && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!v2.de && cnt < 10);
    check("pipe2_de_lag", cnt, 3);

    cnt = 0;
    while (!v2.frame_start && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    nlow = 0;
    for (int i = 0; i < FR; i++) begin
      if (i > 0) @(negedge clk);
      nlow += int'(!v2.hsync);
    end
    check("pipe2_hs_low_clks", nlow, 24);

    cnt = 0;
    while (!(v0.x == 5 && v0.y == 2) && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    fcs = int'(v0.frame_count);
    en = 1'b0;
    @(negedge clk);
    check("endrop_x", v0.x, 0);
    check("endrop_y", v0.y, 0);
    check("endrop_fc", v0.frame_count, fcs);
    @(negedge clk);
    check("endrop_de", v0.de, 0);
    check("endrop_hsync", v0.hsync, 0);
    check("endrop_vsync", v0.vsync, 0);
    repeat (5) @(negedge clk);
    check("endrop_hold_fc", v0.frame_count, fcs);
    en = 1'b1;
    @(negedge clk);
    check("enrise_fs", v0.frame_start, 1);
    check_frame0("restart");

    fcs = int'(v0.frame_count);
    prev = fcs;
    wrapped = 1'b0;
    repeat (256 * FR) begin
      @(negedge clk);
      if (prev == 255 && v0.frame_count == 0)
        wrapped = 1'b1;
      prev = int'(v0.frame_count);
    end
    check("fc_256_frames", v0.frame_count, fcs);
    check("fc_wrap_seen", int'(wrapped), 1);

    repeat (37) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("midrst_x", v0.x, 0);
    check("midrst_y", v0.y, 0);
    check("midrst_fc", v0.frame_count, 0);
    check("midrst_pix_ce", v0.pix_ce, 0);
    check("midrst_de", v0.de, 0);
    check("midrst_hs_pol0", v2.hsync, 1);
    check("midrst_div3_x", v1.x, 0);
    reset_n = 1'b1;
    repeat (30) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
